// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the RV32I datapath.
// The controller side uses the master modport; the datapath (or a bench) uses slave.
interface multicycle_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  // Datapath -> controller
  logic [DATA_WIDTH-1:0] instr;
  logic                  EQ;
  logic                  mem_ready;
  // Controller -> datapath
  logic                  mem_req;
  logic                  mem_we;
  logic                  AdrSrc;
  logic                  IRWrite;
  logic                  PCWrite;
  logic                  PCsrc;
  logic                  ALUsrc;
  logic                  ALUctrl;
  logic [1:0]            ImmSrc;
  logic                  ResultSrc;
  logic                  RegWrite;
  logic                  retire;
  logic                  illegal;
  logic [2:0]            state;

  modport master (
    input  instr, EQ, mem_ready,
    output mem_req, mem_we, AdrSrc, IRWrite, PCWrite, PCsrc, ALUsrc, ALUctrl,
           ImmSrc, ResultSrc, RegWrite, retire, illegal, state
  );

  modport slave (
    output instr, EQ, mem_ready,
    input  mem_req, mem_we, AdrSrc, IRWrite, PCWrite, PCsrc, ALUsrc, ALUctrl,
           ImmSrc, ResultSrc, RegWrite, retire, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I subset core (addi, add/sub, lw, sw, beq/bne).
// Sequences one shared memory port, the ALU, register file and PC through
// FETCH/DECODE/EXEC/MEM/WB. Control outputs are decoded from the state register
// plus instr/EQ/mem_ready so a completing memory handshake acts in the same cycle.
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t state_reg;
  logic   illegal_reg;

  // Instruction fields; the IR is stable from DECODE until the next fetch completes,
  // so decoding combinationally in every state is safe.
  logic [DATA_WIDTH-1:0] ir;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  is_addi, is_alur, is_lw, is_sw, is_br, is_bne, legal;
  logic                  br_taken;
  logic                  unused_ir;

  assign ir     = bus.instr;
  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  // Register indices and immediates are the datapath's business.
  assign unused_ir = ^ir;

  // Instruction classification
  always_comb begin
    is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    is_alur = (opcode == 7'b0110011) && (funct3 == 3'b000) &&
              ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
    is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
    is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
    is_br   = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
    is_bne  = funct3[0];
    legal   = is_addi | is_alur | is_lw | is_sw | is_br;
    br_taken = is_bne ? !bus.EQ : bus.EQ;
  end

  // State sequencing and the sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (bus.mem_ready) state_reg <= DECODE;
        end
        DECODE: begin
          if (legal) begin
            state_reg <= EXEC;
          end else begin
            illegal_reg <= 1'b1;
            state_reg   <= FETCH;
          end
        end
        EXEC: begin
          if (is_addi || is_alur)   state_reg <= WB;
          else if (is_lw || is_sw)  state_reg <= MEM;
          else                      state_reg <= FETCH;
        end
        MEM: begin
          if (bus.mem_ready) state_reg <= is_sw ? FETCH : WB;
        end
        WB:      state_reg <= FETCH;
        default: state_reg <= FETCH;
      endcase
    end
  end

  // Control outputs; everything is forced low while reset is held so no
  // memory request or write can leak out during reset.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.PCsrc     = 1'b0;
    bus.ALUsrc    = 1'b0;
    bus.ALUctrl   = 1'b0;
    bus.ImmSrc    = 2'b00;
    bus.ResultSrc = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.retire    = 1'b0;
    if (rst_n) begin
      case (state_reg)
        FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready) begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
          end
        end
        DECODE: begin
          if (!legal) bus.retire = 1'b1;
        end
        EXEC: begin
          if (is_addi || is_lw) begin
            bus.ALUsrc = 1'b1;
          end else if (is_alur) begin
            bus.ALUctrl = funct7[5];
          end else if (is_sw) begin
            bus.ALUsrc = 1'b1;
            bus.ImmSrc = 2'b01;
          end else if (is_br) begin
            bus.ALUctrl = 1'b1;
            bus.ImmSrc  = 2'b10;
            bus.retire  = 1'b1;
            bus.PCWrite = br_taken;
            bus.PCsrc   = br_taken;
          end
        end
        MEM: begin
          bus.mem_req = 1'b1;
          bus.AdrSrc  = 1'b1;
          bus.mem_we  = is_sw;
          if (bus.mem_ready && is_sw) bus.retire = 1'b1;
        end
        WB: begin
          bus.RegWrite  = 1'b1;
          bus.ResultSrc = is_lw;
          bus.retire    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state   = state_reg;
  assign bus.illegal = illegal_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus randomized
// instruction streams with random memory wait states, checked cycle by cycle
// against a per-instruction expected-output plan and a latency table.
module tb_multicycle_ctrl;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_ctrl_if #(.DATA_WIDTH(DW)) bus ();
  multicycle_ctrl #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCsrc;
    logic       ALUsrc;
    logic       ALUctrl;
    logic [1:0] ImmSrc;
    logic       ResultSrc;
    logic       RegWrite;
    logic       retire;
    logic       illegal;
    logic [2:0] state;
  } obs_t;

  typedef struct packed {
    obs_t v;
    logic rdy;       // mem_ready to drive
    logic rdy_free;  // mem_ready is irrelevant this cycle; drive random
    logic ill_dec;   // decode cycle of an illegal instruction
  } step_t;

  typedef enum int {C_ALUI, C_ALUR, C_LW, C_SW, C_BR, C_ILL} cls_t;

  int n_checks = 0;
  int n_errors = 0;
  int txn = 0;
  logic model_illegal = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.mem_req   = bus.mem_req;
    o.mem_we    = bus.mem_we;
    o.AdrSrc    = bus.AdrSrc;
    o.IRWrite   = bus.IRWrite;
    o.PCWrite   = bus.PCWrite;
    o.PCsrc     = bus.PCsrc;
    o.ALUsrc    = bus.ALUsrc;
    o.ALUctrl   = bus.ALUctrl;
    o.ImmSrc    = bus.ImmSrc;
    o.ResultSrc = bus.ResultSrc;
    o.RegWrite  = bus.RegWrite;
    o.retire    = bus.retire;
    o.illegal   = bus.illegal;
    o.state     = bus.state;
    return o;
  endfunction

  function automatic cls_t classify(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    if (op == 7'b0010011 && f3 == 3'd0) return C_ALUI;
    if (op == 7'b0110011 && f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) return C_ALUR;
    if (op == 7'b0000011 && f3 == 3'd2) return C_LW;
    if (op == 7'b0100011 && f3 == 3'd2) return C_SW;
    if (op == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1)) return C_BR;
    return C_ILL;
  endfunction

  // Cycles from fetch start to retire with no wait states.
  function automatic int base_latency(input cls_t c);
    case (c)
      C_ALUI, C_ALUR: return 4;
      C_LW:           return 5;
      C_SW:           return 4;
      C_BR:           return 3;
      default:        return 2;
    endcase
  endfunction

  function automatic logic [31:0] gen_instr(input int kind);
    logic [31:0] w;
    w = $urandom;
    case (kind)
      0: begin w[6:0] = 7'b0010011; w[14:12] = 3'd0; end
      1: begin w[6:0] = 7'b0110011; w[14:12] = 3'd0; w[31:25] = 7'h00; end
      2: begin w[6:0] = 7'b0110011; w[14:12] = 3'd0; w[31:25] = 7'h20; end
      3: begin w[6:0] = 7'b0000011; w[14:12] = 3'd2; end
      4: begin w[6:0] = 7'b0100011; w[14:12] = 3'd2; end
      5: begin w[6:0] = 7'b1100011; w[14:12] = 3'd0; end
      6: begin w[6:0] = 7'b1100011; w[14:12] = 3'd1; end
      default: begin
        // Near-miss: a legal opcode with random funct fields, re-rolled until illegal
        for (int tries = 0; tries < 100; tries++) begin
          w = $urandom;
          case ($urandom_range(0, 5))
            0: w[6:0] = 7'b0010011;
            1: w[6:0] = 7'b0110011;
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            4: w[6:0] = 7'b1100011;
            default: ;
          endcase
          if ($urandom_range(0, 1) == 1) w[31:25] = 7'h01;
          if (classify(w) == C_ILL) break;
        end
        if (classify(w) != C_ILL) w = 32'h0000_0000;
      end
    endcase
    return w;
  endfunction

  // Runs one instruction starting at posedge+1 in FETCH; fw/mw are wait cycles.
  task automatic run_instr(input logic [31:0] ins, input logic eq, input int fw, input int mw);
    cls_t  c;
    step_t s;
    step_t plan[$];
    obs_t  got;
    int    lat_obs;
    int    exp_lat;
    logic  taken;
    c = classify(ins);
    lat_obs = -1;
    for (int i = 0; i < fw; i++) begin
      s = '0; s.v.mem_req = 1'b1; s.rdy = 1'b0;
      plan.push_back(s);
    end
    s = '0; s.v.mem_req = 1'b1; s.v.IRWrite = 1'b1; s.v.PCWrite = 1'b1; s.rdy = 1'b1;
    plan.push_back(s);
    s = '0; s.v.state = 3'd1; s.rdy_free = 1'b1;
    if (c == C_ILL) begin s.v.retire = 1'b1; s.ill_dec = 1'b1; end
    plan.push_back(s);
    if (c != C_ILL) begin
      s = '0; s.v.state = 3'd2; s.rdy_free = 1'b1;
      case (c)
        C_ALUI: s.v.ALUsrc = 1'b1;
        C_ALUR: s.v.ALUctrl = ins[30];
        C_LW:   s.v.ALUsrc = 1'b1;
        C_SW:   begin s.v.ALUsrc = 1'b1; s.v.ImmSrc = 2'b01; end
        default: begin
          taken = ins[12] ? !eq : eq;
          s.v.ALUctrl = 1'b1; s.v.ImmSrc = 2'b10; s.v.retire = 1'b1;
          s.v.PCWrite = taken; s.v.PCsrc = taken;
        end
      endcase
      plan.push_back(s);
      if (c == C_LW || c == C_SW) begin
        for (int i = 0; i < mw; i++) begin
          s = '0; s.v.state = 3'd3; s.v.mem_req = 1'b1; s.v.AdrSrc = 1'b1;
          s.v.mem_we = (c == C_SW); s.rdy = 1'b0;
          plan.push_back(s);
        end
        s = '0; s.v.state = 3'd3; s.v.mem_req = 1'b1; s.v.AdrSrc = 1'b1;
        s.v.mem_we = (c == C_SW); s.v.retire = (c == C_SW); s.rdy = 1'b1;
        plan.push_back(s);
      end
      if (c == C_ALUI || c == C_ALUR || c == C_LW) begin
        s = '0; s.v.state = 3'd4; s.v.RegWrite = 1'b1; s.v.ResultSrc = (c == C_LW);
        s.v.retire = 1'b1; s.rdy_free = 1'b1;
        plan.push_back(s);
      end
    end

    bus.instr = ins;
    for (int k = 0; k < plan.size(); k++) begin
      s = plan[k];
      bus.mem_ready = s.rdy_free ? 1'($urandom_range(0, 1)) : s.rdy;
      bus.EQ = (s.v.state == 3'd2) ? eq : 1'($urandom_range(0, 1));
      s.v.illegal = model_illegal;
      #4;
      got = observe();
      check_val($sformatf("txn%0d_cyc%0d", txn, k), 32'(got), 32'(s.v));
      if (got.retire && lat_obs < 0) lat_obs = k + 1;
      if (s.ill_dec) model_illegal = 1'b1;
      @(posedge clk);
      #1;
    end
    exp_lat = base_latency(c) + fw + ((c == C_LW || c == C_SW) ? mw : 0);
    check_val($sformatf("txn%0d_latency", txn), 32'(lat_obs), 32'(exp_lat));
    $display("txn %0d instr=%08h eq=%0d fw=%0d mw=%0d latency=%0d", txn, ins, eq, fw, mw, lat_obs);
    txn++;
  endtask

  // Reset asserted mid-MEM of a store: outputs drop at once, then a clean FETCH.
  task automatic reset_in_mem();
    obs_t e;
    bus.instr = 32'h0020A223;
    bus.EQ = 1'b0;
    repeat (3) begin
      bus.mem_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    #2;
    e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.AdrSrc = 1'b1; e.mem_we = 1'b1;
    e.illegal = model_illegal;
    check_val("mem_before_reset", 32'(observe()), 32'(e));
    rst_n = 1'b0;
    #1;
    check_val("reset_in_mem", 32'(observe()), 32'd0);
    model_illegal = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    e = '0; e.mem_req = 1'b1;
    check_val("fetch_after_reset", 32'(observe()), 32'(e));
    @(posedge clk);
    #1;
    $display("txn %0d reset during sw MEM", txn);
    txn++;
  endtask

  initial begin
    obs_t e;
    int   kind, fw, mw;
    bus.instr = '0;
    bus.EQ = 1'b0;
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    check_val("reset_outputs", 32'(observe()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    #3;
    e = '0; e.mem_req = 1'b1;
    check_val("first_fetch", 32'(observe()), 32'(e));
    @(posedge clk);
    #1;

    // Directed cases
    run_instr(32'h00500093, 1'b0, 0, 0);  // addi x1,x0,5
    run_instr(32'h0040A103, 1'b0, 0, 3);  // lw with 3 MEM waits
    run_instr(32'hFE209CE3, 1'b0, 0, 0);  // bne taken
    run_instr(32'hFE209CE3, 1'b1, 0, 0);  // bne not taken
    run_instr(32'h0020A223, 1'b0, 0, 0);  // sw
    run_instr(32'h00000000, 1'b0, 0, 0);  // illegal
    run_instr(32'h00500093, 1'b0, 1, 0);  // addi after illegal, flag stays set
    run_instr(32'h40208133, 1'b0, 2, 0);  // sub
    run_instr(32'h00001093, 1'b0, 0, 0);  // op-imm with funct3=001: illegal
    run_instr(32'h0220A133, 1'b0, 0, 0);  // R-type with funct7=0000001: illegal
    reset_in_mem();
    run_instr(32'h00208463, 1'b1, 0, 0);  // beq taken, after reset
    run_instr(32'h00208463, 1'b0, 0, 0);  // beq not taken

    // Randomized stream; illegals are rarer so the sticky flag is seen both ways
    for (int n = 0; n < 250; n++) begin
      kind = ($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, 6);
      fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      run_instr(gen_instr(kind), 1'($urandom_range(0, 1)), fw, mw);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I subset core. It sequences a single shared memory port, the ALU, the register file and the PC register through FETCH/DECODE/EXEC/MEM/WB, one state per cycle. It waits on a memory ready handshake for every memory access. It replaces single-cycle combinational decode, so the datapath can share one ALU and one memory between instruction fetch and data access.

Parameters:
DATA_WIDTH, 32, instruction/data width.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst_n  in  1  asynchronous reset, active-low.
instr  in  DATA_WIDTH  instruction register contents; stable from DECODE until the next FETCH completes.
EQ  in  1  ALU equality flag (rs1 == rs2), valid in EXEC.
mem_ready  in  1  memory completes the requested access this cycle.
mem_req  out  1  memory access request.
mem_we  out  1  write strobe; valid only with mem_req.
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
IRWrite  out  1  load instruction register.
PCWrite  out  1  load PC.
PCsrc  out  1  PC source: 0 = PC+4, 1 = branch target (OldPC + imm).
ALUsrc  out  1  ALU B operand: 0 = rs2, 1 = immediate.
ALUctrl  out  1  0 = add, 1 = subtract.
ImmSrc  out  2  00 = I-type, 01 = S-type, 10 = B-type.
ResultSrc  out  1  writeback data: 0 = ALUOut, 1 = memory read data.
RegWrite  out  1  register file write enable.
retire  out  1  one-cycle pulse in the final cycle of each instruction, including illegal instructions.
illegal  out  1  sticky flag; set on an undecodable instruction.
state  out  3  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. All outputs are Moore/Mealy functions of state, instr, EQ and mem_ready. Any output not listed for a state is 0.
- Reset (rst_n low, any time): state=FETCH immediately; illegal=0; all outputs 0 while rst_n is low, including mem_req. The first FETCH begins on the first clk edge after rst_n rises. Reset during MEM abandons the access; no write completes from the controller's side.
- FETCH: mem_req=1, AdrSrc=0, mem_we=0.
  - Hold while mem_ready=0; mem_req stays high and the address is stable.
  - In the cycle mem_ready=1: IRWrite=1, PCWrite=1, PCsrc=0; next state DECODE. The datapath latches OldPC.
- DECODE (1 cycle): classify instr.
  - addi: op 0010011, f3 000.
  - add/sub: op 0110011, f3 000, funct7 0000000 or 0100000.
  - lw: op 0000011, f3 010.
  - sw: op 0100011, f3 010.
  - beq/bne: op 1100011, f3 000/001.
  - Legal instruction: next state EXEC.
  - Anything else: set illegal, retire=1, next state FETCH, no architectural writes.
- EXEC (1 cycle):
  - addi: ALUsrc=1, ImmSrc=00, ALUctrl=0; next WB.
  - add/sub: ALUsrc=0, ALUctrl=funct7[5]; next WB.
  - lw: ALUsrc=1, ImmSrc=00, ALUctrl=0; next MEM.
  - sw: ALUsrc=1, ImmSrc=01, ALUctrl=0; next MEM.
  - branch: ALUsrc=0, ALUctrl=1, ImmSrc=10, retire=1; next FETCH.
    - Taken = (bne & !EQ) | (beq & EQ).
    - If taken: PCWrite=1, PCsrc=1. If not taken: PCWrite=0 (PC already holds PC+4).
- MEM: mem_req=1, AdrSrc=1, mem_we=1 for sw, 0 for lw.
  - Hold while mem_ready=0.
  - On mem_ready=1: lw goes to WB; sw sets retire=1 and goes to FETCH.
- WB (1 cycle): RegWrite=1, ResultSrc=1 for lw, 0 otherwise; retire=1; next FETCH. Writes to rd=x0 are still issued; the register file discards them.
- Latency with mem_ready tied high:
  - addi/add/sub: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch: 3 cycles.
  - illegal: 2 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- Invariants:
  - RegWrite and mem_we are never both 1.
  - IRWrite only in FETCH.
  - illegal clears only on reset.

Test Plan:
1. rst_n low while in MEM with mem_req=1 -> mem_req=0 and state=0 before the next clk edge; after release, FETCH with AdrSrc=0 and mem_req=1.
2. instr=0x00500093 (addi x1,x0,5), mem_ready=1 -> states 0,1,2,4; ALUsrc=1 and ImmSrc=00 in EXEC; RegWrite=1, ResultSrc=0 and retire=1 in cycle 4 only.
3. instr=0x0040A103 (lw x2,4(x1)), mem_ready low for 3 MEM cycles -> mem_req=1 and AdrSrc=1 held 4 cycles, mem_we=0; then WB with ResultSrc=1 and RegWrite=1; total 8 cycles.
4. instr=0xFE209CE3 (bne x1,x2,-8) -> EQ=0 gives PCWrite=1, PCsrc=1 in EXEC; EQ=1 gives PCWrite=0; both return to FETCH after 3 cycles with RegWrite never asserted.
5. instr=0x0020A223 (sw x2,4(x1)) -> ImmSrc=01 in EXEC; mem_we=1 only in MEM; retire on mem_ready; RegWrite never 1; 4 cycles.
6. instr=0x00000000 -> illegal=1 after DECODE and remains 1 through a following addi; retire=1 in DECODE; no RegWrite or mem_we; next state FETCH.
